// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if
//   Bundles the two requester ports and the ALU-facing signals of
//   alu_share_ctrl. CLK and reset stay plain ports on the controller.
//
//   modport slave  : the controller (alu_share_ctrl).
//   modport master : the environment, meaning requester front-ends plus the ALU.
//
//   Signals:
//     pX_req_valid/pX_req_ready   request handshake, X = 0,1
//     pX_a, pX_b, pX_op           operands and ALU op code for requester X
//     pX_resp_valid/pX_resp_ready response handshake for requester X
//     resp_data, resp_lt          registered ALU result, shared by both ports
//     alu_a, alu_b, alu_op        operands/op driven into the ALU
//     alu_rst                     ALU reset/start pulse
//     alu_o, alu_lt               ALU result and less_than flag
//
//   Handshake: a transfer happens on a rising CLK edge where valid and ready
//   are both high. A source that raises valid holds valid and its payload
//   stable until that edge. Ready may depend combinationally on valid.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             p0_req_valid;
  logic             p1_req_valid;
  logic             p0_req_ready;
  logic             p1_req_ready;
  logic [WIDTH-1:0] p0_a;
  logic [WIDTH-1:0] p0_b;
  logic [WIDTH-1:0] p1_a;
  logic [WIDTH-1:0] p1_b;
  logic [2:0]       p0_op;
  logic [2:0]       p1_op;
  logic             p0_resp_valid;
  logic             p1_resp_valid;
  logic             p0_resp_ready;
  logic             p1_resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_lt;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             alu_rst;
  logic [WIDTH-1:0] alu_o;
  logic             alu_lt;

  modport slave (
    input  p0_req_valid, p1_req_valid,
    output p0_req_ready, p1_req_ready,
    input  p0_a, p0_b, p1_a, p1_b, p0_op, p1_op,
    output p0_resp_valid, p1_resp_valid,
    input  p0_resp_ready, p1_resp_ready,
    output resp_data, resp_lt,
    output alu_a, alu_b, alu_op, alu_rst,
    input  alu_o, alu_lt
  );

  modport master (
    output p0_req_valid, p1_req_valid,
    input  p0_req_ready, p1_req_ready,
    output p0_a, p0_b, p1_a, p1_b, p0_op, p1_op,
    input  p0_resp_valid, p1_resp_valid,
    output p0_resp_ready, p1_resp_ready,
    input  resp_data, resp_lt,
    input  alu_a, alu_b, alu_op, alu_rst,
    output alu_o, alu_lt
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one multi-cycle ALU between two requesters. The controller
//   arbitrates, latches the winner's operands and op, pulses the ALU reset
//   for one cycle, waits an op-dependent number of cycles, captures the
//   result and hands it back to the winning requester.
//
//   Parameters:
//     WIDTH    operand/result width
//     LAT_FAST wait cycles for ops 000..110 (>= 1)
//     LAT_MOD  wait cycles for op 111, mod (>= 1)
//
//   Ports:
//     CLK       clock, rising edge
//     reset     asynchronous, active-high reset
//     bus       alu_share_ctrl_if.slave (requester ports + ALU side)
//     dbg_state current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
//   Build option:
//     ALU_SHARE_FIXED_PRIORITY_EN  when defined, port 0 always wins a tie
//                                  and no round-robin state is kept.
//                                  When undefined, ties alternate.
//
//   Handshake: a transfer happens on a rising CLK edge where valid and ready
//   are both high. pX_req_ready depends combinationally on pX_req_valid.
//   pX_resp_valid is a decode of registered state.
module alu_share_ctrl #(
  parameter int WIDTH    = 32,
  parameter int LAT_FAST = 2,
  parameter int LAT_MOD  = 48
) (
  input  logic               CLK,
  input  logic               reset,
  alu_share_ctrl_if.slave    bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int LAT_MAX = (LAT_FAST > LAT_MOD) ? LAT_FAST : LAT_MOD;
  localparam int CW      = $clog2(LAT_MAX) + 1;
  localparam logic [CW-1:0] CNT_FAST = CW'(LAT_FAST - 1);
  localparam logic [CW-1:0] CNT_MOD  = CW'(LAT_MOD - 1);

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic             owner;       // 0: port 0 owns the op in flight, 1: port 1
  logic             grant;       // port that may handshake in IDLE
  logic             accept;      // request handshake this cycle
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;

  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifdef ALU_SHARE_FIXED_PRIORITY_EN
  always_comb begin
    grant = bus.p0_req_valid ? 1'b0 : 1'b1;
  end
`else
  // last holds the port served by the most recent request handshake. It
  // resets to 1 so that port 0 wins the first tie.
  logic last;

  always_comb begin
    grant = 1'b0;
    if (bus.p0_req_valid && bus.p1_req_valid) begin
      grant = ~last;
    end else if (bus.p1_req_valid) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant;
    end
  end
`endif

  always_comb begin
    sel_a  = grant ? bus.p1_a  : bus.p0_a;
    sel_b  = grant ? bus.p1_b  : bus.p0_b;
    sel_op = grant ? bus.p1_op : bus.p0_op;
  end

  // ---------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    next_state        = state;
    accept            = 1'b0;
    bus.p0_req_ready  = 1'b0;
    bus.p1_req_ready  = 1'b0;
    bus.p0_resp_valid = 1'b0;
    bus.p1_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.p0_req_ready = (grant == 1'b0) && bus.p0_req_valid;
        bus.p1_req_ready = (grant == 1'b1) && bus.p1_req_valid;
        accept = bus.p0_req_ready || bus.p1_req_ready;
        if (accept) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          next_state = RESP;
        end
      end
      RESP: begin
        // The non-owner's resp_ready is deliberately not looked at.
        bus.p0_resp_valid = ~owner;
        bus.p1_resp_valid = owner;
        if (owner ? bus.p1_resp_ready : bus.p0_resp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  // alu_rst is registered off next_state, so it is high for exactly the
  // ISSUE cycle. It resets to 1 so the ALU is held in reset alongside the
  // controller.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      owner         <= 1'b0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_op    <= '0;
      bus.alu_rst   <= 1'b1;
      bus.resp_data <= '0;
      bus.resp_lt   <= 1'b0;
    end else begin
      bus.alu_rst <= (next_state == ISSUE);
      if (accept) begin
        owner      <= grant;
        bus.alu_a  <= sel_a;
        bus.alu_b  <= sel_b;
        bus.alu_op <= sel_op;
        cnt        <= (sel_op == 3'b111) ? CNT_MOD : CNT_FAST;
      end
      if (state == WAIT) begin
        if (cnt == '0) begin
          bus.resp_data <= bus.alu_o;
          bus.resp_lt   <= bus.alu_lt;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
//   Directed bench for alu_share_ctrl. A behavioural ALU answers with the
//   correct result only once enough cycles have passed since its reset
//   pulse, and with a corrupted value before that. Each accepted request
//   pushes {port, lt, data} onto exp_q. The entry is popped when the
//   response appears.
module tb_alu_share_ctrl;
  localparam int WIDTH       = 32;
  localparam int LAT_FAST    = 2;
  localparam int LAT_MOD     = 48;
  localparam int EW          = WIDTH + 2;
  localparam int SEND_BUDGET = 20;
  localparam int RESP_BUDGET = 200;
`ifdef ALU_SHARE_FIXED_PRIORITY_EN
  localparam int TIE2_FIRST  = 0;
`else
  localparam int TIE2_FIRST  = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [EW-1:0] exp_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  alu_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

  alu_share_ctrl #(
    .WIDTH(WIDTH), .LAT_FAST(LAT_FAST), .LAT_MOD(LAT_MOD)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural ALU ----------------
  int unsigned      alu_busy = 0;
  int unsigned      alu_need;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cmp;

  always @(posedge CLK) begin
    if (bus.alu_rst) alu_busy <= 0;
    else if (alu_busy < 1000) alu_busy <= alu_busy + 1;
  end

  always_comb begin
    alu_cmp  = $signed(bus.alu_a) < $signed(bus.alu_b);
    alu_need = (bus.alu_op == 3'b111) ? LAT_MOD - 1 : LAT_FAST - 1;
    case (bus.alu_op)
      3'b000:  alu_res = bus.alu_a & bus.alu_b;
      3'b001:  alu_res = bus.alu_a | bus.alu_b;
      3'b010:  alu_res = bus.alu_a ^ bus.alu_b;
      3'b011:  alu_res = ~(bus.alu_a | bus.alu_b);
      3'b100:  alu_res = {{(WIDTH-1){1'b0}}, alu_cmp};
      3'b101:  alu_res = bus.alu_a + bus.alu_b;
      3'b110:  alu_res = bus.alu_a - bus.alu_b;
      default: alu_res = (bus.alu_b == '0) ? bus.alu_a : bus.alu_a % bus.alu_b;
    endcase
    if (alu_busy >= alu_need) begin
      bus.alu_o  = alu_res;
      bus.alu_lt = alu_cmp;
    end else begin
      bus.alu_o  = alu_res ^ 32'hBAD0_BAD0;
      bus.alu_lt = ~alu_cmp;
    end
  end

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [2:0] op);
    if (port == 0) begin
      bus.p0_req_valid = v; bus.p0_a = a; bus.p0_b = b; bus.p0_op = op;
    end else begin
      bus.p1_req_valid = v; bus.p1_a = a; bus.p1_b = b; bus.p1_op = op;
    end
  endtask

  function automatic logic req_ready(input int port);
    return (port == 0) ? bus.p0_req_ready : bus.p1_req_ready;
  endfunction

  function automatic logic resp_valid(input int port);
    return (port == 0) ? bus.p0_resp_valid : bus.p1_resp_valid;
  endfunction

  // Call at a falling edge. hs returns the number of the handshake edge.
  task automatic send(input int port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [2:0] op, input logic [WIDTH-1:0] exp_d,
                      input logic exp_lt, output int hs);
    bit seen = 0;
    logic [0:0] p;
    p = port[0];
    hs = cyc;
    set_req(port, 1'b1, a, b, op);
    for (int i = 0; i < SEND_BUDGET && !seen; i++) begin
      #1;
      if (req_ready(port)) seen = 1;
      else @(negedge CLK);
    end
    check($sformatf("p%0d_req_ready_seen", port), seen, 1);
    if (!seen) begin
      set_req(port, 1'b0, a, b, op);
      return;
    end
    check($sformatf("p%0d_other_ready_low", port), req_ready(1 - port), 0);
    hs = cyc + 1;
    @(negedge CLK);
    set_req(port, 1'b0, a, b, op);
    check("req_ready_drops", req_ready(port), 0);
    check("alu_rst_in_issue", bus.alu_rst, 1);
    check("alu_a_latched", bus.alu_a, a);
    check("alu_b_latched", bus.alu_b, b);
    check("alu_op_latched", bus.alu_op, op);
    exp_q.push_back({p, exp_lt, exp_d});
  endtask

  // resp_valid must first be seen at the falling edge after edge hs+lat+1.
  task automatic wait_resp(input int port, input int lat, input int hs);
    bit seen = 0, other = 0, rst_hi = 0;
    logic [0:0] p;
    logic [EW-1:0] exp;
    p = port[0];
    for (int i = 0; i < RESP_BUDGET && !seen; i++) begin
      @(negedge CLK);
      if (resp_valid(1 - port)) other = 1;
      if (resp_valid(port)) seen = 1;
      else if (bus.alu_rst) rst_hi = 1;
    end
    check($sformatf("p%0d_resp_valid_seen", port), seen, 1);
    check("other_resp_valid_low", other, 0);
    check("alu_rst_single_cycle", rst_hi, 0);
    if (!seen) return;
    check($sformatf("p%0d_resp_latency", port), cyc - hs, lat + 1);
    check("exp_q_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check($sformatf("p%0d_resp", port), {p, bus.resp_lt, bus.resp_data}, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int hs;
    int m;
    int f;
    int s;
    bit any_resp;
    logic [WIDTH-1:0] ta [2];
    logic [WIDTH-1:0] tb [2];
    logic [2:0]       top [2];
    logic [WIDTH-1:0] td [2];
    logic             tl [2];

    set_req(0, 1'b0, '0, '0, 3'b000);
    set_req(1, 1'b0, '0, '0, 3'b000);
    bus.p0_resp_ready = 1'b1;
    bus.p1_resp_ready = 1'b1;

    // reset values
    repeat (3) @(negedge CLK);
    check("rst_alu_rst", bus.alu_rst, 1);
    check("rst_state", dbg_state, 0);
    check("rst_p0_req_ready", bus.p0_req_ready, 0);
    check("rst_p1_req_ready", bus.p1_req_ready, 0);
    check("rst_p0_resp_valid", bus.p0_resp_valid, 0);
    check("rst_p1_resp_valid", bus.p1_resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_resp_lt", bus.resp_lt, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_op", bus.alu_op, 0);
    reset = 1'b0;
    @(negedge CLK);
    check("alu_rst_released", bus.alu_rst, 0);

    // port 0 alone: 23 mod 5
    send(0, 23, 5, 3'b111, 3, 1'b0, hs);
    wait_resp(0, LAT_MOD, hs);
    @(negedge CLK);
    check("p0_resp_valid_done", bus.p0_resp_valid, 0);
    check("operands_kept_in_idle", bus.alu_a, 23);

    // port 1 alone: 7 and 2
    send(1, 32'h7, 32'h2, 3'b000, 32'h2, 1'b0, hs);
    wait_resp(1, LAT_FAST, hs);
    @(negedge CLK);

    // tie straight out of reset: port 0 first, then port 1
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    set_req(1, 1'b1, 23, 2, 3'b110);
    send(0, 15, 2, 3'b101, 17, 1'b0, hs);
    wait_resp(0, LAT_FAST, hs);
    send(1, 23, 2, 3'b110, 21, 1'b0, hs);
    wait_resp(1, LAT_FAST, hs);
    @(negedge CLK);

    // backpressure on an slt result, then a second tie
    bus.p0_resp_ready = 1'b0;
    send(0, 1, 6, 3'b100, 1, 1'b1, hs);
    wait_resp(0, LAT_FAST, hs);
    ta[0] = 3;  tb[0] = 4; top[0] = 3'b101; td[0] = 7;  tl[0] = 1'b1;
    ta[1] = 9;  tb[1] = 4; top[1] = 3'b001; td[1] = 13; tl[1] = 1'b0;
    set_req(0, 1'b1, ta[0], tb[0], top[0]);
    set_req(1, 1'b1, ta[1], tb[1], top[1]);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_resp_valid", bus.p0_resp_valid, 1);
      check("bp_resp_lt", bus.resp_lt, 1);
      check("bp_resp_data", bus.resp_data, 1);
      check("bp_p0_req_ready", bus.p0_req_ready, 0);
      check("bp_p1_req_ready", bus.p1_req_ready, 0);
      check("bp_alu_a_stable", bus.alu_a, 1);
    end
    bus.p0_resp_ready = 1'b1;
    m = cyc + 1;
    @(negedge CLK);
    check("bp_resp_valid_done", bus.p0_resp_valid, 0);
    f = TIE2_FIRST;
    s = 1 - TIE2_FIRST;
    send(f, ta[f], tb[f], top[f], td[f], tl[f], hs);
    check("accept_after_resp", hs, m + 1);
    wait_resp(f, LAT_FAST, hs);
    send(s, ta[s], tb[s], top[s], td[s], tl[s], hs);
    wait_resp(s, LAT_FAST, hs);
    @(negedge CLK);

    // reset during WAIT of a mod op
    send(0, 100, 7, 3'b111, 2, 1'b0, hs);
    repeat (10) @(negedge CLK);
    reset = 1'b1;
    #1;
    check("midrst_alu_rst", bus.alu_rst, 1);
    check("midrst_state", dbg_state, 0);
    check("midrst_alu_a", bus.alu_a, 0);
    check("midrst_alu_b", bus.alu_b, 0);
    check("midrst_alu_op", bus.alu_op, 0);
    check("midrst_resp_data", bus.resp_data, 0);
    check("midrst_resp_lt", bus.resp_lt, 0);
    check("midrst_p0_resp_valid", bus.p0_resp_valid, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge CLK);
    reset = 1'b0;
    any_resp = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (bus.p0_resp_valid || bus.p1_resp_valid) any_resp = 1;
    end
    check("no_resp_after_reset", any_resp, 0);
    send(1, 32'h0F, 32'hF0, 3'b011, 32'hFFFF_FF00, 1'b1, hs);
    wait_resp(1, LAT_FAST, hs);
    @(negedge CLK);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
